mdu_div_unit: RTL
=================

# mdu_div_unit

Iterative radix-2 signed/unsigned integer divider that is the responder side of the MDU divide request/response interface. The MDU pipe stage drives the divide request fields and consumes the divide response fields. This block sits inside the multiply/divide unit beside the multiplier. It produces one quotient/remainder pair per accepted request, and it supports flush-abort and response backpressure.

## Interface
- `WIDTH`, 32, operand/result width; the iteration counter is `$clog2(WIDTH)` bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  divide request; a single-cycle pulse from the initiator's DRIVE state.
- `req_ready`  in  1  downstream writeback ready; the response is held until this is high.
- `req_flush`  in  1  synchronous abort of any in-flight operation.
- `req_signed`  in  1  1 = two's-complement operands, 0 = unsigned.
- `req_dividend`  in  WIDTH  dividend.
- `req_divisor`  in  WIDTH  divisor.
- `rsp_ready`  out  1  unit idle and able to accept a request.
- `rsp_valid`  out  1  quotient/remainder valid.
- `rsp_quotient`  out  WIDTH  quotient.
- `rsp_remainder`  out  WIDTH  remainder.

## Operation
- FSM states: IDLE, CALC, DONE.
- Reset (`rst_n`=0 at an edge): state IDLE, `rsp_valid`=0, `rsp_ready`=1, quotient=0, remainder=0, counter=0.
- `rsp_ready` = (state==IDLE). `rsp_valid` = (state==DONE).
- IDLE, on `req_valid` & ~`req_flush`:
  - Latch absolute values of both operands. Absolute values are taken only when `req_signed`=1.
  - Record the quotient sign as the XOR of the operand signs. Record the remainder sign as the dividend sign.
  - Clear the partial remainder and the counter, then go to CALC.
- Fast paths, taken instead of CALC and going straight to DONE with the result registered:
  - Divisor == 0: quotient = all ones, remainder = dividend (raw input value).
  - Signed overflow (`req_signed`, dividend = 1 followed by WIDTH-1 zeros, divisor = all ones): quotient = dividend, remainder = 0.
- CALC: one restoring step per cycle.
  - Shift the partial remainder left, bringing in the next dividend MSB.
  - If the partial remainder ≥ |divisor|: subtract, and the quotient bit = 1. Otherwise the quotient bit = 0.
  - The compare and subtract are WIDTH+1 bits wide.
  - The counter increments each step. On the step where counter == WIDTH-1, apply the sign fixup (two's-complement negate where the recorded sign is 1), register both results and go to DONE.
- DONE: results held stable. Go to IDLE on the first edge with `req_ready`=1.
- `req_flush` at any edge, in any state: next state IDLE, `rsp_valid`=0, and any request presented in the same cycle is dropped. Result registers are not required to clear.
- `req_valid` outside IDLE is a protocol violation. It is ignored, and the bench flags it with an assertion.

## Timing
- Request sampled at edge E0, with `rsp_ready`=1 before E0.
- Normal path: iterations occur at edges E1..E32 (WIDTH=32). `rsp_valid` rises after E32, i.e. 33 cycles after the request cycle.
- Fast path: `rsp_valid` rises after E0, i.e. 1 cycle after the request cycle.
- With `req_ready` high, `rsp_valid` lasts exactly 1 cycle and `rsp_ready` returns in the next cycle. Back-to-back requests are therefore spaced at least 34 cycles apart on the normal path.
- Backpressure: `rsp_valid`, `rsp_quotient` and `rsp_remainder` stay constant for as long as `req_ready`=0.
- Reset and flush take precedence over every transition. Reset mid-CALC gives IDLE and `rsp_ready`=1 after that edge.
- Flush in the same cycle that DONE sees `req_ready`: go to IDLE (same result, no conflict).

## Test plan
- Unsigned 100 / 7 → quotient 14, remainder 2. `rsp_valid` high for exactly 1 cycle, 33 cycles after the request, with `req_ready`=1.
- Signed 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also check unsigned 0xFFFFFFF9 / 2 → quotient 0x7FFFFFFC, remainder 1.
- Divide by zero, 5 / 0 (both signed and unsigned) → quotient 0xFFFFFFFF, remainder 5, `rsp_valid` 1 cycle after the request.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, 1-cycle latency. The same operands unsigned → quotient 0, remainder 0x80000000 after 33 cycles.
- Flush at CALC step 10 → `rsp_valid` never asserts and `rsp_ready`=1 the next cycle. A following request, 1000 / 3, returns quotient 333, remainder 1.
- Hold `req_ready`=0 for 5 cycles in DONE for 0xFFFFFFFF / 0x10 → `rsp_valid`=1 with quotient 0x0FFFFFFF and remainder 0xF stable across all 5 cycles. IDLE follows the first ready edge. A random compare against the reference model covers 10k operand pairs.

Source files
------------

// File: rtl/mdu_div_unit.sv
// mdu_div_unit: iterative radix-2 restoring divider, signed or unsigned.
// Each accepted request yields one quotient/remainder pair. A flush aborts
// any operation in progress, and the result is held while writeback stalls.
module mdu_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_ready,
    input  logic             req_flush,
    input  logic             req_signed,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    output logic             rsp_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  dvd_q, dvd_d;    // |dividend|, shifted out MSB first
    logic [WIDTH-1:0]  dvs_q, dvs_d;    // |divisor|
    logic [WIDTH-1:0]  prem_q, prem_d;  // partial remainder
    logic [WIDTH-1:0]  quo_q, quo_d;    // unsigned quotient bits collected so far
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [WIDTH-1:0]  quot_q, quot_d;  // registered final quotient
    logic [WIDTH-1:0]  rem_q, rem_d;    // registered final remainder

    // Operand magnitudes and the special cases that bypass iteration
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_abs, b_abs;
    logic              div_zero, sgn_ovf;

    assign a_neg    = req_signed & req_dividend[WIDTH-1];
    assign b_neg    = req_signed & req_divisor[WIDTH-1];
    assign a_abs    = a_neg ? (~req_dividend + 1'b1) : req_dividend;
    assign b_abs    = b_neg ? (~req_divisor + 1'b1) : req_divisor;
    assign div_zero = (req_divisor == '0);
    assign sgn_ovf  = req_signed
                    & (req_dividend == {1'b1, {(WIDTH-1){1'b0}}})
                    & (req_divisor == '1);

    // One restoring step: shift in the next dividend bit and compare at WIDTH+1 bits
    logic [WIDTH:0]    trial;
    logic [WIDTH:0]    diff;
    logic              ge;
    logic [WIDTH-1:0]  step_rem;
    logic [WIDTH-1:0]  step_quo;

    assign trial    = {prem_q, dvd_q[WIDTH-1]};
    assign diff     = trial - {1'b0, dvs_q};
    assign ge       = (trial >= {1'b0, dvs_q});
    assign step_rem = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign step_quo = {quo_q[WIDTH-2:0], ge};

    assign rsp_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == DONE);
    assign rsp_quotient  = quot_q;
    assign rsp_remainder = rem_q;

    // State and datapath registers; reset clears the results and the counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state and datapath update; flush overrides every transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        case (state_q)
            IDLE: begin
                if (req_valid && !req_flush) begin
                    if (div_zero) begin
                        quot_d  = '1;
                        rem_d   = req_dividend;
                        state_d = DONE;
                    end else if (sgn_ovf) begin
                        quot_d  = req_dividend;
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        dvd_d   = a_abs;
                        dvs_d   = b_abs;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        prem_d  = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                prem_d = step_rem;
                quo_d  = step_quo;
                dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    quot_d  = qneg_q ? (~step_quo + 1'b1) : step_quo;
                    rem_d   = rneg_q ? (~step_rem + 1'b1) : step_rem;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (req_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (req_flush) begin
            state_d = IDLE;
        end
    end

endmodule
